// File: rtl/arb_serial_pkg.sv
// arb_serial_pkg: shared types and constants for the arb_serial_32_8 serializer.
package arb_serial_pkg;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_PAR = 2'd2} state_t;
    function automatic logic [BYTE_W-1:0] xor_bytes(input logic [WORD_W-1:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction
endpackage

// File: rtl/arb_serial_32_8_rr_pick.sv
// rr_pick: combinational round-robin picker.
//  req_valid in  N_REQ  pending requests
//  rr_ptr    in  SEL_W  highest-priority index this round
//  winner    out SEL_W  first valid index at or after rr_ptr, wrapping
//  any       out 1      at least one request pending
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);
    logic [SEL_W-1:0] hi, lo;
    logic             hi_any;
    // Descending scan leaves the lowest index in each half; the half at/above
    // rr_ptr takes priority, so no modulo arithmetic is needed for non-pow2 N_REQ.
    always_comb begin
        hi = '0;
        lo = '0;
        hi_any = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                if (k >= int'(rr_ptr)) begin
                    hi = SEL_W'(k);
                    hi_any = 1'b1;
                end else begin
                    lo = SEL_W'(k);
                end
            end
        end
        winner = hi_any ? hi : lo;
        any = |req_valid;
    end
endmodule

// File: rtl/arb_serial_32_8.sv
// arb_serial_32_8: round-robin arbiter feeding one 32->8 LSB-first byte serializer.
//  clk, reset (async, active-high)
//  req_valid/req_data/req_ready : N_REQ word requesters, one-hot ready in IDLE only
//  out_valid/out_data/out_ready : byte stream, tagged with out_sel/out_first/out_last
//  busy                         : word in flight
//  Optional macro PARITY_BYTE_EN appends an XOR-of-bytes parity byte to every word.
module arb_serial_32_8
    import arb_serial_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SEL_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [WORD_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [BYTE_W-1:0]       out_data,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_first,
    output logic                    out_last,
    output logic                    busy
);
    state_t             state, state_n;
    logic [SEL_W-1:0]   rr_ptr, winner;
    logic [1:0]         byte_idx;
    logic [WORD_W-1:0]  word_q;
    logic               any, last_byte;

    rr_pick #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_pick (
        .req_valid(req_valid),
        .rr_ptr(rr_ptr),
        .winner(winner),
        .any(any)
    );

    assign busy = state != ST_IDLE;
    assign last_byte = byte_idx == 2'(BYTES_PER_WORD - 1);

    always_comb begin
        state_n = state;
        req_ready = '0;
        out_valid = 1'b0;
        out_data = '0;
        out_first = 1'b0;
        out_last = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = any ? N_REQ'(1) << winner : '0;
                if (any) state_n = ST_SEND;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                out_data = word_q[BYTE_W*byte_idx +: BYTE_W];
                out_first = byte_idx == 2'd0;
`ifdef PARITY_BYTE_EN
                if (out_ready && last_byte) state_n = ST_PAR;
`else
                out_last = last_byte;
                if (out_ready && last_byte) state_n = ST_IDLE;
`endif
            end
`ifdef PARITY_BYTE_EN
            ST_PAR: begin
                out_valid = 1'b1;
                out_data = xor_bytes(word_q);
                out_last = 1'b1;
                if (out_ready) state_n = ST_IDLE;
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            rr_ptr <= '0;
            byte_idx <= '0;
            word_q <= '0;
            out_sel <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && any) begin
                word_q <= req_data[WORD_W*winner +: WORD_W];
                out_sel <= winner;
                byte_idx <= '0;
                rr_ptr <= (winner == SEL_W'(N_REQ - 1)) ? '0 : winner + SEL_W'(1);
            end else if (state == ST_SEND && out_ready) begin
                // Wraps 3 -> 0 naturally on the last byte.
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_arb_serial_32_8.sv
// tb_arb_serial_32_8: directed self-checking bench for arb_serial_32_8.
module tb_arb_serial_32_8;
`ifdef PARITY_BYTE_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         out_ready = 1'b1;
    logic [1:0]   out_sel;
    logic         out_first;
    logic         out_last;
    logic         busy;
    int           total = 0;
    int           bad = 0;

    arb_serial_32_8 #(.N_REQ(4), .SEL_W(2)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .out_sel(out_sel),
        .out_first(out_first),
        .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // {busy, out_valid, out_sel, out_first, out_last, out_data}
    wire [13:0] obs = {busy, out_valid, out_sel, out_first, out_last, out_data};

    function automatic logic [7:0] ebyte(input logic [31:0] w, input int k);
        return k < 4 ? w[8*k +: 8] : w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

    function automatic logic [13:0] eobs(input logic [1:0] s, input logic [31:0] w, input int k);
        return {1'b1, 1'b1, s, k == 0, k == NB - 1, ebyte(w, k)};
    endfunction

    function automatic logic [13:0] eidle(input logic [1:0] s);
        return {2'b00, s, 10'b0};
    endfunction

    function automatic logic [31:0] rr_word(input int i);
        return {8'(i*16+3), 8'(i*16+2), 8'(i*16+1), 8'(i*16)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req_valid = '0;
        out_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        req_valid = '0;
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (obs !== 14'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", obs, 14'h0); end
        total++;
        if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single;
        req_data[31:0] = 32'hDDCCBBAA;
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0;
        total++;
        if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_send got=%b exp=0000", req_ready); end
        for (int k = 0; k < NB; k++) begin
            total++;
            if (obs !== eobs(2'd0, 32'hDDCCBBAA, k)) begin
                bad++; $display("FAIL single_byte k=%0d got=%h exp=%h", k, obs, eobs(2'd0, 32'hDDCCBBAA, k));
            end
            tick();
        end
        total++;
        if (obs !== eidle(2'd0)) begin bad++; $display("FAIL single_idle got=%h exp=%h", obs, eidle(2'd0)); end
    endtask

    task automatic test_round_robin;
        do_reset();
        for (int i = 0; i < 4; i++) req_data[32*i +: 32] = rr_word(i);
        req_valid = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            total++;
            if (req_ready !== 4'(1 << (g % 4))) begin
                bad++; $display("FAIL rr_grant g=%0d got=%b exp=%b", g, req_ready, 4'(1 << (g % 4)));
            end
            tick();
            for (int k = 0; k < NB; k++) begin
                total++;
                if (obs !== eobs(2'(g % 4), rr_word(g % 4), k)) begin
                    bad++; $display("FAIL rr_byte g=%0d k=%0d got=%h exp=%h", g, k, obs, eobs(2'(g % 4), rr_word(g % 4), k));
                end
                tick();
            end
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_bubble g=%0d got=%b exp=0", g, out_valid); end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        do_reset();
        req_data[63:32] = 32'h44332211;
        req_valid = 4'b0010;
        #1;
        tick();
        req_valid = '0;
        total++;
        if (obs !== eobs(2'd1, 32'h44332211, 0)) begin bad++; $display("FAIL bp_byte0 got=%h exp=%h", obs, eobs(2'd1, 32'h44332211, 0)); end
        tick();
        total++;
        if (obs !== eobs(2'd1, 32'h44332211, 1)) begin bad++; $display("FAIL bp_byte1 got=%h exp=%h", obs, eobs(2'd1, 32'h44332211, 1)); end
        out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
            tick();
            total++;
            if (obs !== eobs(2'd1, 32'h44332211, 1)) begin
                bad++; $display("FAIL bp_hold h=%0d got=%h exp=%h", h, obs, eobs(2'd1, 32'h44332211, 1));
            end
        end
        out_ready = 1'b1;
        tick();
        for (int k = 2; k < NB; k++) begin
            total++;
            if (obs !== eobs(2'd1, 32'h44332211, k)) begin
                bad++; $display("FAIL bp_byte k=%0d got=%h exp=%h", k, obs, eobs(2'd1, 32'h44332211, k));
            end
            tick();
        end
        total++;
        if (obs !== eidle(2'd1)) begin bad++; $display("FAIL bp_idle got=%h exp=%h", obs, eidle(2'd1)); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        req_data[95:64] = 32'h88776655;
        req_valid = 4'b0100;
        #1;
        tick();
        req_valid = '0;
        total++;
        if (obs !== eobs(2'd2, 32'h88776655, 0)) begin bad++; $display("FAIL rmid_byte0 got=%h exp=%h", obs, eobs(2'd2, 32'h88776655, 0)); end
        tick();
        tick();
        total++;
        if (obs !== eobs(2'd2, 32'h88776655, 2)) begin bad++; $display("FAIL rmid_byte2 got=%h exp=%h", obs, eobs(2'd2, 32'h88776655, 2)); end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (obs !== 14'h0) begin bad++; $display("FAIL rmid_async got=%h exp=%h", obs, 14'h0); end
        reset = 1'b0;
        req_data[31:0] = 32'hDDCCBBAA;
        req_valid = 4'hF;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_regrant got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0;
        total++;
        if (obs !== eobs(2'd0, 32'hDDCCBBAA, 0)) begin bad++; $display("FAIL rmid_newword got=%h exp=%h", obs, eobs(2'd0, 32'hDDCCBBAA, 0)); end
    endtask

    task automatic test_fairness;
        do_reset();
        req_data[31:0] = 32'h0A0B0C0D;
        req_data[95:64] = 32'h20212223;
        req_valid = 4'b0001;
        #1;
        tick();
        tick();
        req_valid = 4'b0101;
        for (int k = 1; k < NB; k++) tick();
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL fair_req2 got=%b exp=0100", req_ready); end
        tick();
        req_valid = 4'b0001;
        for (int k = 0; k < NB; k++) begin
            total++;
            if (obs !== eobs(2'd2, 32'h20212223, k)) begin
                bad++; $display("FAIL fair_byte k=%0d got=%h exp=%h", k, obs, eobs(2'd2, 32'h20212223, k));
            end
            tick();
        end
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL fair_back0 got=%b exp=0001", req_ready); end
        req_valid = '0;
    endtask

`ifdef PARITY_BYTE_EN
    task automatic test_parity;
        logic [7:0] exp_b [5];
        exp_b = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h04};
        do_reset();
        req_data[127:96] = 32'h01020304;
        req_valid = 4'b1000;
        #1;
        tick();
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({out_valid, out_data, out_last} !== {1'b1, exp_b[k], k == 4}) begin
                bad++; $display("FAIL par_byte k=%0d got=%b_%h_%b exp=1_%h_%b", k, out_valid, out_data, out_last, exp_b[k], k == 4);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL par_idle got=%b exp=0", out_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_fairness();
`ifdef PARITY_BYTE_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
